score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper_if.sv | 25 ++
 rtl/score_keeper.sv | 120 ++++++++++++
 tb/tb_score_keeper.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// Bus bundle for the whack-a-mole score keeper: game inputs and display outputs.
interface score_keeper_if;
    logic       Start;
    logic       Hit;
    logic       Miss;
    logic       Tick;
    logic [7:0] Score;
    logic [7:0] HighScore;
    logic [5:0] TimeLeft;
    logic       Playing;
    logic       GameOver;
    logic       NewHigh;

    // Game controller side: drives the requests, observes the scoreboard.
    modport master (
        output Start, Hit, Miss, Tick,
        input  Score, HighScore, TimeLeft, Playing, GameOver, NewHigh
    );

    // Score keeper side.
    modport slave (
        input  Start, Hit, Miss, Tick,
        output Score, HighScore, TimeLeft, Playing, GameOver, NewHigh
    );
endinterface

// File: rtl/score_keeper.sv
// Round timer, saturating score counter and high-score tracker for a
// whack-a-mole game. Three-state FSM: IDLE -> PLAY -> OVER -> PLAY ...
module score_keeper #(
    parameter int GAME_SECONDS = 30,
    parameter int MAX_SCORE    = 99
) (
    input  logic          Clock,
    input  logic          Reset,
    score_keeper_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] score_reg;
    logic [7:0] high_score_reg;
    logic [5:0] time_left_reg;
    logic       new_high_reg;
    logic       round_end_reg;
    logic       hit_d_reg;
    logic       miss_d_reg;
    logic       playing;
    logic       game_over;

    // Edge detection on the level inputs; the delayed copies run in every state
    // so a level held across Reset release or round start never counts.
    logic hit_event;
    logic miss_event;
    logic start_round;
    logic last_tick;

    assign hit_event   = bus.Hit & ~hit_d_reg;
    assign miss_event  = bus.Miss & ~miss_d_reg;
    assign start_round = (state_reg != PLAY) && bus.Start;
    assign last_tick   = (state_reg == PLAY) && bus.Tick && (time_left_reg <= 6'd1);

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: Start only matters outside PLAY; the final Tick ends the round.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.Start) state_next = PLAY;
            PLAY:    if (last_tick) state_next = OVER;
            OVER:    if (bus.Start) state_next = PLAY;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded purely from the state register.
    always_comb begin
        playing   = 1'b0;
        game_over = 1'b0;
        case (state_reg)
            PLAY:    playing   = 1'b1;
            OVER:    game_over = 1'b1;
            default: ;
        endcase
    end

    // Score, timer and high-score datapath. round_end_reg marks the first OVER
    // cycle so the high-score compare happens exactly once per completed round;
    // Reset clears it, so an abandoned round never reaches the compare.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            score_reg      <= 8'd0;
            high_score_reg <= 8'd0;
            time_left_reg  <= 6'd0;
            new_high_reg   <= 1'b0;
            round_end_reg  <= 1'b0;
            hit_d_reg      <= 1'b0;
            miss_d_reg     <= 1'b0;
        end else begin
            hit_d_reg     <= bus.Hit;
            miss_d_reg    <= bus.Miss;
            new_high_reg  <= 1'b0;
            round_end_reg <= last_tick;

            if (start_round) begin
                score_reg     <= 8'd0;
                time_left_reg <= 6'(GAME_SECONDS);
            end else if (state_reg == PLAY) begin
                // Simultaneous hit and miss cancel out.
                if (hit_event && !miss_event) begin
                    if (score_reg < 8'(MAX_SCORE)) score_reg <= score_reg + 8'd1;
                end else if (miss_event && !hit_event) begin
                    if (score_reg != 8'd0) score_reg <= score_reg - 8'd1;
                end
                if (bus.Tick && (time_left_reg != 6'd0)) begin
                    time_left_reg <= time_left_reg - 6'd1;
                end
            end

            if (round_end_reg && (score_reg > high_score_reg)) begin
                high_score_reg <= score_reg;
                new_high_reg   <= 1'b1;
            end
        end
    end

    assign bus.Score     = score_reg;
    assign bus.HighScore = high_score_reg;
    assign bus.TimeLeft  = time_left_reg;
    assign bus.Playing   = playing;
    assign bus.GameOver  = game_over;
    assign bus.NewHigh   = new_high_reg;

endmodule

// File: tb/tb_score_keeper.sv
// Directed testbench for score_keeper: one instance with the default round
// length, one with a 3-second round for end-of-round scenarios.
module tb_score_keeper;

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    score_keeper_if ifa ();
    score_keeper_if ifb ();

    score_keeper #(.GAME_SECONDS(30), .MAX_SCORE(99)) dut_a (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (ifa.slave)
    );

    score_keeper #(.GAME_SECONDS(3), .MAX_SCORE(99)) dut_b (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (ifb.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Advance one rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drv_a(input logic s, input logic h, input logic m, input logic t);
        ifa.Start = s; ifa.Hit = h; ifa.Miss = m; ifa.Tick = t;
        step();
    endtask

    task automatic drv_b(input logic s, input logic h, input logic m, input logic t);
        ifb.Start = s; ifb.Hit = h; ifb.Miss = m; ifb.Tick = t;
        step();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        ifa.Start = 0; ifa.Hit = 0; ifa.Miss = 0; ifa.Tick = 0;
        ifb.Start = 0; ifb.Hit = 0; ifb.Miss = 0; ifb.Tick = 0;
        step();
        Reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        ifa.Start = 1; ifa.Hit = 1; ifa.Miss = 0; ifa.Tick = 1;
        step();
        checks++; if (ifa.Playing !== 1'b0) begin errors++; $display("FAIL reset_playing got %0b want 0", ifa.Playing); end
        checks++; if (ifa.GameOver !== 1'b0) begin errors++; $display("FAIL reset_gameover got %0b want 0", ifa.GameOver); end
        checks++; if (ifa.Score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", ifa.Score); end
        checks++; if (ifa.HighScore !== 8'd0) begin errors++; $display("FAIL reset_high got %0d want 0", ifa.HighScore); end
        checks++; if (ifa.TimeLeft !== 6'd0) begin errors++; $display("FAIL reset_time got %0d want 0", ifa.TimeLeft); end
        checks++; if (ifa.NewHigh !== 1'b0) begin errors++; $display("FAIL reset_newhigh got %0b want 0", ifa.NewHigh); end
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        drv_a(1, 0, 0, 0);
        drv_a(0, 0, 0, 0);
        checks++; if (ifa.Playing !== 1'b1) begin errors++; $display("FAIL start_playing got %0b want 1", ifa.Playing); end
        checks++; if (ifa.TimeLeft !== 6'd30) begin errors++; $display("FAIL start_time got %0d want 30", ifa.TimeLeft); end
        for (int i = 0; i < 5; i++) begin drv_a(0, 1, 0, 0); drv_a(0, 0, 0, 0); end
        for (int i = 0; i < 2; i++) begin drv_a(0, 0, 1, 0); drv_a(0, 0, 0, 0); end
        checks++; if (ifa.Score !== 8'd3) begin errors++; $display("FAIL basic_score got %0d want 3", ifa.Score); end
        checks++; if (ifa.TimeLeft !== 6'd30) begin errors++; $display("FAIL basic_time got %0d want 30", ifa.TimeLeft); end
        checks++; if (ifa.Playing !== 1'b1) begin errors++; $display("FAIL basic_playing got %0b want 1", ifa.Playing); end
        $display("test_basic done");
    endtask

    task automatic test_floor_ceiling();
        do_reset();
        drv_a(1, 0, 0, 0);
        drv_a(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin drv_a(0, 0, 1, 0); drv_a(0, 0, 0, 0); end
        checks++; if (ifa.Score !== 8'd0) begin errors++; $display("FAIL floor_score got %0d want 0", ifa.Score); end
        for (int i = 0; i < 99; i++) begin drv_a(0, 1, 0, 0); drv_a(0, 0, 0, 0); end
        checks++; if (ifa.Score !== 8'd99) begin errors++; $display("FAIL reach_max got %0d want 99", ifa.Score); end
        for (int i = 0; i < 2; i++) begin drv_a(0, 1, 0, 0); drv_a(0, 0, 0, 0); end
        checks++; if (ifa.Score !== 8'd99) begin errors++; $display("FAIL ceiling_score got %0d want 99", ifa.Score); end
        drv_a(0, 0, 1, 0); drv_a(0, 0, 0, 0);
        checks++; if (ifa.Score !== 8'd98) begin errors++; $display("FAIL miss_from_max got %0d want 98", ifa.Score); end
        $display("test_floor_ceiling done");
    endtask

    task automatic test_hold_and_coincident();
        do_reset();
        drv_a(1, 0, 0, 0);
        drv_a(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drv_a(0, 1, 0, 0);
        drv_a(0, 0, 0, 0);
        checks++; if (ifa.Score !== 8'd1) begin errors++; $display("FAIL hold_hit got %0d want 1", ifa.Score); end
        drv_a(0, 1, 1, 0);
        drv_a(0, 0, 0, 0);
        checks++; if (ifa.Score !== 8'd1) begin errors++; $display("FAIL hit_miss_same got %0d want 1", ifa.Score); end
        $display("test_hold_and_coincident done");
    endtask

    task automatic test_start_ignored();
        do_reset();
        drv_a(1, 1, 0, 0);
        checks++; if (ifa.Score !== 8'd0) begin errors++; $display("FAIL entry_edge_hit got %0d want 0", ifa.Score); end
        drv_a(0, 0, 0, 0);
        drv_a(0, 0, 0, 1);
        checks++; if (ifa.TimeLeft !== 6'd29) begin errors++; $display("FAIL tick_play got %0d want 29", ifa.TimeLeft); end
        drv_a(1, 0, 0, 0);
        drv_a(0, 0, 0, 0);
        checks++; if (ifa.TimeLeft !== 6'd29) begin errors++; $display("FAIL start_in_play got %0d want 29", ifa.TimeLeft); end
        $display("test_start_ignored done");
    endtask

    task automatic test_hit_through_reset();
        Reset = 1'b1;
        ifa.Start = 0; ifa.Hit = 1; ifa.Miss = 0; ifa.Tick = 0;
        step();
        Reset = 1'b0;
        drv_a(0, 1, 0, 0);
        drv_a(1, 1, 0, 0);
        drv_a(0, 1, 0, 0);
        drv_a(0, 1, 0, 0);
        checks++; if (ifa.Score !== 8'd0) begin errors++; $display("FAIL hit_through_reset got %0d want 0", ifa.Score); end
        drv_a(0, 0, 0, 1);
        checks++; if (ifa.TimeLeft !== 6'd29) begin errors++; $display("FAIL idle_tick_not_counted got %0d want 29", ifa.TimeLeft); end
        $display("test_hit_through_reset done");
    endtask

    task automatic test_round_end();
        do_reset();
        drv_b(0, 0, 0, 1);
        checks++; if (ifb.TimeLeft !== 6'd0) begin errors++; $display("FAIL idle_tick got %0d want 0", ifb.TimeLeft); end
        drv_b(1, 0, 0, 0);
        drv_b(0, 0, 0, 0);
        checks++; if (ifb.TimeLeft !== 6'd3) begin errors++; $display("FAIL short_load got %0d want 3", ifb.TimeLeft); end
        for (int i = 0; i < 7; i++) begin drv_b(0, 1, 0, 0); drv_b(0, 0, 0, 0); end
        for (int i = 0; i < 2; i++) begin drv_b(0, 0, 0, 1); drv_b(0, 0, 0, 0); end
        checks++; if (ifb.TimeLeft !== 6'd1) begin errors++; $display("FAIL two_ticks got %0d want 1", ifb.TimeLeft); end
        drv_b(0, 0, 0, 1);
        checks++; if (ifb.GameOver !== 1'b1) begin errors++; $display("FAIL end_gameover got %0b want 1", ifb.GameOver); end
        checks++; if (ifb.Playing !== 1'b0) begin errors++; $display("FAIL end_playing got %0b want 0", ifb.Playing); end
        checks++; if (ifb.TimeLeft !== 6'd0) begin errors++; $display("FAIL end_time got %0d want 0", ifb.TimeLeft); end
        checks++; if (ifb.HighScore !== 8'd0) begin errors++; $display("FAIL end_high_early got %0d want 0", ifb.HighScore); end
        checks++; if (ifb.NewHigh !== 1'b0) begin errors++; $display("FAIL end_newhigh_early got %0b want 0", ifb.NewHigh); end
        drv_b(0, 0, 0, 1);
        checks++; if (ifb.HighScore !== 8'd7) begin errors++; $display("FAIL high_update got %0d want 7", ifb.HighScore); end
        checks++; if (ifb.NewHigh !== 1'b1) begin errors++; $display("FAIL newhigh_pulse got %0b want 1", ifb.NewHigh); end
        checks++; if (ifb.TimeLeft !== 6'd0) begin errors++; $display("FAIL over_tick got %0d want 0", ifb.TimeLeft); end
        drv_b(0, 1, 0, 0);
        checks++; if (ifb.NewHigh !== 1'b0) begin errors++; $display("FAIL newhigh_one_cycle got %0b want 0", ifb.NewHigh); end
        drv_b(0, 0, 0, 0);
        checks++; if (ifb.Score !== 8'd7) begin errors++; $display("FAIL over_hold_score got %0d want 7", ifb.Score); end
        drv_b(1, 0, 0, 0);
        drv_b(0, 0, 0, 0);
        checks++; if (ifb.Score !== 8'd0) begin errors++; $display("FAIL restart_score got %0d want 0", ifb.Score); end
        for (int i = 0; i < 5; i++) begin drv_b(0, 1, 0, 0); drv_b(0, 0, 0, 0); end
        for (int i = 0; i < 3; i++) begin drv_b(0, 0, 0, 1); drv_b(0, 0, 0, 0); end
        checks++; if (ifb.GameOver !== 1'b1) begin errors++; $display("FAIL second_over got %0b want 1", ifb.GameOver); end
        checks++; if (ifb.Score !== 8'd5) begin errors++; $display("FAIL second_score got %0d want 5", ifb.Score); end
        checks++; if (ifb.HighScore !== 8'd7) begin errors++; $display("FAIL high_kept got %0d want 7", ifb.HighScore); end
        checks++; if (ifb.NewHigh !== 1'b0) begin errors++; $display("FAIL no_newhigh got %0b want 0", ifb.NewHigh); end
        $display("test_round_end done");
    endtask

    task automatic test_final_tick_hit();
        do_reset();
        drv_b(1, 0, 0, 0);
        drv_b(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin drv_b(0, 1, 0, 0); drv_b(0, 0, 0, 0); end
        for (int i = 0; i < 2; i++) begin drv_b(0, 0, 0, 1); drv_b(0, 0, 0, 0); end
        drv_b(0, 1, 0, 1);
        checks++; if (ifb.GameOver !== 1'b1) begin errors++; $display("FAIL final_tick_over got %0b want 1", ifb.GameOver); end
        checks++; if (ifb.Score !== 8'd5) begin errors++; $display("FAIL final_tick_hit got %0d want 5", ifb.Score); end
        drv_b(0, 0, 0, 0);
        checks++; if (ifb.HighScore !== 8'd5) begin errors++; $display("FAIL final_tick_high got %0d want 5", ifb.HighScore); end
        $display("test_final_tick_hit done");
    endtask

    task automatic test_reset_mid_round();
        do_reset();
        drv_a(1, 0, 0, 0);
        drv_a(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin drv_a(0, 1, 0, 0); drv_a(0, 0, 0, 0); end
        for (int i = 0; i < 21; i++) begin drv_a(0, 0, 0, 1); drv_a(0, 0, 0, 0); end
        checks++; if (ifa.Score !== 8'd12) begin errors++; $display("FAIL mid_score got %0d want 12", ifa.Score); end
        checks++; if (ifa.TimeLeft !== 6'd9) begin errors++; $display("FAIL mid_time got %0d want 9", ifa.TimeLeft); end
        Reset = 1'b1;
        step();
        checks++; if (ifa.Playing !== 1'b0) begin errors++; $display("FAIL abort_playing got %0b want 0", ifa.Playing); end
        checks++; if (ifa.Score !== 8'd0) begin errors++; $display("FAIL abort_score got %0d want 0", ifa.Score); end
        checks++; if (ifa.TimeLeft !== 6'd0) begin errors++; $display("FAIL abort_time got %0d want 0", ifa.TimeLeft); end
        Reset = 1'b0;
        drv_a(0, 0, 0, 0);
        drv_a(0, 0, 0, 0);
        checks++; if (ifa.HighScore !== 8'd0) begin errors++; $display("FAIL abort_high got %0d want 0", ifa.HighScore); end
        checks++; if (ifa.GameOver !== 1'b0) begin errors++; $display("FAIL abort_gameover got %0b want 0", ifa.GameOver); end
        $display("test_reset_mid_round done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        ifa.Start = 0; ifa.Hit = 0; ifa.Miss = 0; ifa.Tick = 0;
        ifb.Start = 0; ifb.Hit = 0; ifb.Miss = 0; ifb.Tick = 0;
        step();
        test_reset();
        test_basic();
        test_floor_ceiling();
        test_hold_and_coincident();
        test_start_ignored();
        test_hit_through_reset();
        test_round_end();
        test_final_tick_hit();
        test_reset_mid_round();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
